// File: rtl/best_1ofn_busy_cclut_pipe_pkg.sv
// Shared ccLUT pattern-finder constants, candidate record and tree-sizing helpers
// for the pipelined best-1-of-N selector.
package best_1ofn_busy_cclut_pipe_pkg;

    localparam int unsigned MXPATB = 7;
    localparam int unsigned MXKEYB = 5;
    localparam int unsigned MXPATC = 11;
    // Index field is sized for the largest supported NCFEB (8)
    localparam int unsigned MXIDXB = 3;

    typedef struct packed {
        logic              elig;
        logic [MXPATB-1:0] pat;
        logic [MXKEYB-1:0] key;
        logic [MXPATC-1:0] carry;
        logic [MXIDXB-1:0] idx;
    } cand_t;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned w = 1; w < n; w = w * 2) r++;
        return r;
    endfunction

    // Node count at tree level lvl (level 0 = registered inputs); odd nodes pass through
    function automatic int unsigned level_count(input int unsigned n, input int unsigned lvl);
        int unsigned c;
        c = n;
        for (int unsigned k = 0; k < lvl; k++) c = (c + 1) / 2;
        return c;
    endfunction

    function automatic int unsigned level_base(input int unsigned n, input int unsigned lvl);
        int unsigned b;
        b = 0;
        for (int unsigned k = 0; k < lvl; k++) b += level_count(n, k);
        return b;
    endfunction

endpackage

// File: rtl/best_1ofn_busy_cclut_pipe_if.sv
// Candidate-set input bus and best-candidate result bus of the best-1-of-N selector.
interface best_1ofn_busy_cclut_pipe_if
    import best_1ofn_busy_cclut_pipe_pkg::*;
#(
    parameter int unsigned NCFEB = 7
);
    localparam int unsigned MXCFEBB = clog2(NCFEB);

    logic                        vld_in;
    logic [NCFEB*MXPATB-1:0]     pat_in;
    logic [NCFEB*MXKEYB-1:0]     key_in;
    logic [NCFEB*MXPATC-1:0]     carry_in;
    logic [NCFEB-1:0]            bsy_in;

    logic                        best_vld;
    logic [MXPATB-1:0]           best_pat;
    logic [MXKEYB+MXCFEBB-1:0]   best_key;
    logic [MXPATC-1:0]           best_carry;
    logic                        best_bsy;

    modport master (
        output vld_in, pat_in, key_in, carry_in, bsy_in,
        input  best_vld, best_pat, best_key, best_carry, best_bsy
    );

    modport slave (
        input  vld_in, pat_in, key_in, carry_in, bsy_in,
        output best_vld, best_pat, best_key, best_carry, best_bsy
    );

endinterface

// File: rtl/best_1ofn_busy_cclut_pipe_best_of2.sv
// Registered 2-input tree node: keeps the eligible candidate with the larger sort key,
// the left (lower-index) input on ties or when neither is eligible.
module best_1ofn_busy_cclut_pipe_best_of2
    import best_1ofn_busy_cclut_pipe_pkg::*;
(
    input  logic  clock,
    input  logic  reset,
    input  logic  vld,
    input  cand_t a,
    input  cand_t b,
    output cand_t y
);

    cand_t sel;

    // Bend bit [0] is excluded from the comparison
    always_comb begin
        sel = a;
        if (b.elig && (!a.elig || (b.pat[MXPATB-1:1] > a.pat[MXPATB-1:1]))) begin
            sel = b;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || !vld) begin
            y <= '0;
        end else begin
            y <= sel;
        end
    end

endmodule

// File: rtl/best_1ofn_busy_cclut_pipe.sv
// Pipelined busy-aware best-1-of-N CFEB pattern selector, latency clog2(NCFEB)+1.
// Optional per-CFEB dead-time after a win: define CCLUT_BEST_DEADTIME_EN.
module best_1ofn_busy_cclut_pipe
    import best_1ofn_busy_cclut_pipe_pkg::*;
#(
    parameter int unsigned NCFEB    = 7,
    parameter int unsigned DEADTIME = 4
)(
    input  logic                         clock,
    input  logic                         reset,
    best_1ofn_busy_cclut_pipe_if.slave   bus
);

    localparam int unsigned MXCFEBB = clog2(NCFEB);
    localparam int unsigned NLVL    = MXCFEBB;
    localparam int unsigned NNODE   = level_base(NCFEB, NLVL + 1);

    cand_t            stage_q [NCFEB];
    cand_t            node    [NNODE];
    logic [NLVL:0]    vld_q;
    logic [NCFEB-1:0] elig;
    cand_t            root;
    logic             win;

    assign root = node[NNODE-1];
    assign win  = vld_q[NLVL] && root.elig;

`ifdef CCLUT_BEST_DEADTIME_EN
    localparam logic [3:0] DtLoad = 4'(DEADTIME);

    logic [3:0] dtcnt_q [NCFEB];

    // Reload on the winning channel has priority over the per-clock decrement
    always_ff @(posedge clock) begin
        for (int i = 0; i < NCFEB; i++) begin
            if (reset) begin
                dtcnt_q[i] <= '0;
            end else if (win && (root.idx == MXIDXB'(i))) begin
                dtcnt_q[i] <= DtLoad;
            end else if (dtcnt_q[i] != '0) begin
                dtcnt_q[i] <= dtcnt_q[i] - 4'd1;
            end
        end
    end

    always_comb begin
        elig = '0;
        for (int i = 0; i < NCFEB; i++) begin
            elig[i] = !bus.bsy_in[i] && (dtcnt_q[i] == '0);
        end
    end
`else
    always_comb begin
        elig = ~bus.bsy_in;
    end
`endif

    always_ff @(posedge clock) begin
        for (int i = 0; i < NCFEB; i++) begin
            if (reset || !bus.vld_in) begin
                stage_q[i] <= '0;
            end else begin
                stage_q[i].elig  <= elig[i];
                stage_q[i].pat   <= bus.pat_in[i*MXPATB +: MXPATB];
                stage_q[i].key   <= bus.key_in[i*MXKEYB +: MXKEYB];
                stage_q[i].carry <= bus.carry_in[i*MXPATC +: MXPATC];
                stage_q[i].idx   <= MXIDXB'(i);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            vld_q <= '0;
        end else begin
            vld_q <= {vld_q[NLVL-1:0], bus.vld_in};
        end
    end

    for (genvar i = 0; i < NCFEB; i++) begin : g_leaf
        assign node[i] = stage_q[i];
    end

    // Flat node array: level l occupies [level_base(l) +: level_count(l)]
    for (genvar l = 1; l <= NLVL; l++) begin : g_lvl
        localparam int unsigned PrevBase = level_base(NCFEB, l - 1);
        localparam int unsigned PrevCnt  = level_count(NCFEB, l - 1);
        localparam int unsigned Base     = level_base(NCFEB, l);
        localparam int unsigned Cnt      = level_count(NCFEB, l);
        for (genvar j = 0; j < Cnt; j++) begin : g_node
            if (2 * j + 1 < PrevCnt) begin : g_pair
                best_1ofn_busy_cclut_pipe_best_of2 u_node (
                    .clock (clock),
                    .reset (reset),
                    .vld   (vld_q[l-1]),
                    .a     (node[PrevBase + 2*j]),
                    .b     (node[PrevBase + 2*j + 1]),
                    .y     (node[Base + j])
                );
            end else begin : g_pass
                best_1ofn_busy_cclut_pipe_best_of2 u_node (
                    .clock (clock),
                    .reset (reset),
                    .vld   (vld_q[l-1]),
                    .a     (node[PrevBase + 2*j]),
                    .b     ('0),
                    .y     (node[Base + j])
                );
            end
        end
    end

    always_comb begin
        bus.best_vld   = vld_q[NLVL];
        bus.best_bsy   = 1'b0;
        bus.best_pat   = '0;
        bus.best_key   = '0;
        bus.best_carry = '0;
        if (win) begin
            bus.best_pat   = root.pat;
            bus.best_key   = {root.idx[MXCFEBB-1:0], root.key};
            bus.best_carry = root.carry;
        end else if (vld_q[NLVL]) begin
            bus.best_bsy = 1'b1;
        end
    end

endmodule

// File: tb/tb_best_1ofn_busy_cclut_pipe.sv
// Bench for best_1ofn_busy_cclut_pipe: directed vector table, reset flush and randomized
// sets checked against a queue-based scan-for-maximum reference model.
module tb_best_1ofn_busy_cclut_pipe;
    import best_1ofn_busy_cclut_pipe_pkg::*;

    localparam int unsigned N   = 7;
    localparam int unsigned DT  = 4;
    localparam int unsigned CB  = clog2(N);
    localparam int unsigned LAT = CB + 1;
    localparam int unsigned KB  = MXKEYB + CB;

    typedef logic [N*MXPATB-1:0] pat_v;
    typedef logic [N*MXKEYB-1:0] key_v;
    typedef logic [N*MXPATC-1:0] car_v;

    typedef struct packed {
        logic              vld;
        logic              bsy;
        logic [MXPATB-1:0] pat;
        logic [KB-1:0]     key;
        logic [MXPATC-1:0] carry;
    } out_t;

    typedef struct {
        logic [N-1:0] bsy;
        pat_v         pat;
        out_t         exp;
    } vec_t;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    best_1ofn_busy_cclut_pipe_if #(.NCFEB(N)) bus ();

    best_1ofn_busy_cclut_pipe #(.NCFEB(N), .DEADTIME(DT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    out_t q[$];
    int   n_pass   = 0;
    int   n_checks = 0;
`ifdef CCLUT_BEST_DEADTIME_EN
    int unsigned dt [N];
`endif

    // Linear scan over channels, strict '>' keeps the lowest index on ties
    function automatic out_t model(input logic [N-1:0] el, input pat_v p, input key_v k,
                                   input car_v c);
        out_t o;
        int   best;
        logic [MXPATB-2:0] bk;
        o    = '0;
        best = -1;
        bk   = '0;
        for (int i = 0; i < N; i++) begin
            if (el[i] && (best < 0 || p[i*MXPATB+1 +: MXPATB-1] > bk)) begin
                best = i;
                bk   = p[i*MXPATB+1 +: MXPATB-1];
            end
        end
        o.vld = 1'b1;
        if (best < 0) begin
            o.bsy = 1'b1;
        end else begin
            o.pat   = p[best*MXPATB +: MXPATB];
            o.key   = {CB'(best), k[best*MXKEYB +: MXKEYB]};
            o.carry = c[best*MXPATC +: MXPATC];
        end
        return o;
    endfunction

    function automatic pat_v mkpat(input logic [6*N-1:0] keys, input logic [N-1:0] bend);
        pat_v p;
        for (int i = 0; i < N; i++) p[i*MXPATB +: MXPATB] = {keys[i*6 +: 6], bend[i]};
        return p;
    endfunction

    task automatic check(input string name, input out_t got, input out_t exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s @%0t: got vld=%b bsy=%b pat=%h key=%h carry=%h, required vld=%b bsy=%b pat=%h key=%h carry=%h",
                     name, $time, got.vld, got.bsy, got.pat, got.key, got.carry,
                     exp.vld, exp.bsy, exp.pat, exp.key, exp.carry);
        end
    endtask

    // One clock: sample and check this cycle's output, then drive the next set
    task automatic tick(input logic v, input logic [N-1:0] b, input pat_v p, input key_v k,
                        input car_v c, input logic r, output out_t got);
        out_t exp;
        logic [N-1:0] el;
        @(negedge clock);
        got = '{vld: bus.best_vld, bsy: bus.best_bsy, pat: bus.best_pat,
                key: bus.best_key, carry: bus.best_carry};
        exp = q.pop_front();
        check("pipe", got, exp);
        bus.vld_in   = v;
        bus.bsy_in   = b;
        bus.pat_in   = p;
        bus.key_in   = k;
        bus.carry_in = c;
        reset        = r;
        if (r) begin
            q.delete();
            repeat (LAT) q.push_back('0);
`ifdef CCLUT_BEST_DEADTIME_EN
            for (int i = 0; i < N; i++) dt[i] = 0;
`endif
        end else begin
            for (int i = 0; i < N; i++) begin
                el[i] = !b[i];
`ifdef CCLUT_BEST_DEADTIME_EN
                el[i] = el[i] && (dt[i] == 0);
`endif
            end
            q.push_back(v ? model(el, p, k, c) : out_t'('0));
`ifdef CCLUT_BEST_DEADTIME_EN
            for (int i = 0; i < N; i++) begin
                if (exp.vld && !exp.bsy && (exp.key[KB-1 -: CB] == CB'(i))) dt[i] = DT;
                else if (dt[i] > 0) dt[i]--;
            end
`endif
        end
    endtask

    task automatic idle(input int n);
        out_t got;
        repeat (n) tick(1'b0, '0, '0, '0, '0, 1'b0, got);
    endtask

    task automatic rand_set(output logic [N-1:0] b, output pat_v p, output key_v k,
                            output car_v c);
        b = ($urandom_range(0, 9) == 0) ? '1 : N'($urandom & $urandom & $urandom);
        for (int i = 0; i < N; i++) begin
            p[i*MXPATB +: MXPATB] = $urandom_range(0, 1) ? MXPATB'($urandom_range(0, 15))
                                                        : MXPATB'($urandom);
        end
        k = key_v'({$urandom, $urandom});
        c = car_v'({$urandom, $urandom, $urandom});
    endtask

    vec_t tbl [6];
    key_v kb;
    car_v cbv;

    initial begin
        out_t got;
        logic [N-1:0] b;
        pat_v p;
        key_v k;
        car_v c;

        for (int i = 0; i < N; i++) begin
            kb[i*MXKEYB +: MXKEYB]  = MXKEYB'(10 + i);
            cbv[i*MXPATC +: MXPATC] = MXPATC'(100 + i);
        end
        tbl[0] = '{7'h00, mkpat({6'd5, 6'd0, 6'd1, 6'd2, 6'd9, 6'd9, 6'd3}, 7'h7F),
                   '{1'b1, 1'b0, 7'h13, 8'h2B, 11'd101}};
        tbl[1] = '{7'h41, mkpat({6'h3F, 6'h00, 6'h1F, 6'h05, 6'h20, 6'h10, 6'h30}, 7'h00),
                   '{1'b1, 1'b0, 7'h40, 8'h4C, 11'd102}};
        tbl[2] = '{7'h7F, mkpat({6'd5, 6'd0, 6'd1, 6'd2, 6'd9, 6'd9, 6'd3}, 7'h7F),
                   '{1'b1, 1'b1, 7'h00, 8'h00, 11'd0}};
        tbl[3] = '{7'h00, mkpat('0, 7'h00), '{1'b1, 1'b0, 7'h00, 8'h0A, 11'd100}};
        tbl[4] = '{7'h3F, mkpat({6'd5, 6'd0, 6'd1, 6'd2, 6'd9, 6'd9, 6'd3}, 7'h7F),
                   '{1'b1, 1'b0, 7'h0B, 8'hD0, 11'd106}};
        tbl[5] = '{7'h01, mkpat({6'd1, 6'd1, 6'd1, 6'd1, 6'd1, 6'd1, 6'd1}, 7'h40),
                   '{1'b1, 1'b0, 7'h02, 8'h2B, 11'd101}};

        reset        = 1'b1;
        bus.vld_in   = 1'b0;
        bus.bsy_in   = '0;
        bus.pat_in   = '0;
        bus.key_in   = '0;
        bus.carry_in = '0;
        repeat (LAT) q.push_back('0);
`ifdef CCLUT_BEST_DEADTIME_EN
        for (int i = 0; i < N; i++) dt[i] = 0;
`endif
        @(posedge clock);
        tick(1'b0, '0, '0, '0, '0, 1'b0, got);
        check("reset", got, '0);

        foreach (tbl[v]) begin
            tick(1'b1, tbl[v].bsy, tbl[v].pat, kb, cbv, 1'b0, got);
            repeat (LAT) tick(1'b0, '0, '0, '0, '0, 1'b0, got);
            check($sformatf("table%0d", v), got, tbl[v].exp);
            idle(DT + 2);
        end

        // Ten back-to-back sets
        repeat (10) begin
            rand_set(b, p, k, c);
            tick(1'b1, b, p, k, c, 1'b0, got);
        end
        idle(LAT + DT + 1);

        // Reset with three sets in flight
        repeat (3) begin
            rand_set(b, p, k, c);
            tick(1'b1, '0, p, k, c, 1'b0, got);
        end
        rand_set(b, p, k, c);
        tick(1'b1, '0, p, k, c, 1'b1, got);
        tick(1'b0, '0, '0, '0, '0, 1'b0, got);
        check("reset_flush", got, '0);
        idle(LAT + 1);

        // Identical sets every clock, CFEB3 the unique maximum
        p = mkpat({6'd4, 6'd3, 6'd2, 6'd30, 6'd7, 6'd6, 6'd5}, 7'h08);
        repeat (20) tick(1'b1, '0, p, kb, cbv, 1'b0, got);
        idle(LAT + DT + 1);

        for (int n = 0; n < 400; n++) begin
            rand_set(b, p, k, c);
            tick($urandom_range(0, 3) != 0, b, p, k, c, $urandom_range(0, 79) == 0, got);
        end
        idle(LAT + 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
